pmdatapath_seq: RTL and testbench

Parametrised, sequenced successor to the fixed 4-bit accumulator datapath. It has a WIDTH-bit accumulator, an NREG-entry register file, an ALU and an optional multi-cycle shift-add multiplier. Opcodes arrive one at a time over a valid/ready command port and are executed under a small FSM, with a done pulse and status flags per command. It sits between the processor's control unit (command source) and the register/accumulator observation outputs.

---
 rtl/pmdatapath_seq_pkg.sv | 44 ++++
 rtl/pmdatapath_seq_if.sv | 23 ++
 rtl/pmdatapath_seq_alu.sv | 56 +++++
 rtl/pmdatapath_seq.sv | 161 ++++++++++++++++
 tb/tb_pmdatapath_seq.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmdatapath_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : pm_pkg
// Brief  : Opcodes, FSM state encoding and opcode helpers for pmdatapath_seq.
//          Opcode 12 is legal only when PM_MUL_EN is defined.
// Rev    : 1.0
// ============================================================================
package pm_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDR = 4'd1;
    localparam logic [3:0] OP_LDA = 4'd2;
    localparam logic [3:0] OP_STA = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_SHL = 4'd10;
    localparam logic [3:0] OP_SHR = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
`ifdef PM_MUL_EN
        return (op <= OP_MUL);
`else
        return (op <= OP_SHR);
`endif
    endfunction

    // Single-cycle opcodes that write acc, carry and zero.
    function automatic logic writes_acc(input logic [3:0] op);
        return (op == OP_LDA) || ((op >= OP_ADD) && (op <= OP_SHR));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmdatapath_seq_if.sv
`default_nettype none
// ============================================================================
// Module : pmdatapath_seq_if
// Brief  : Valid/ready command port between control unit and pmdatapath_seq.
// Rev    : 1.0
// ============================================================================
interface pmdatapath_seq_if #(
    parameter int WIDTH = 4,
    parameter int NREG  = 4
);
    localparam int AW = $clog2(NREG);

    logic             valid;
    logic             ready;
    logic [3:0]       op;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             cin;

    modport master (output valid, op, addr, data, cin, input ready);
    modport slave  (input valid, op, addr, data, cin, output ready);
endinterface
`default_nettype wire

// File: rtl/pmdatapath_seq_alu.sv
`default_nettype none
// ============================================================================
// Module : pmalu_gen
// Brief  : Combinational WIDTH-bit ALU for the single-cycle opcodes.
// Rev    : 1.0
// ============================================================================
module pmalu_gen
    import pm_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] i_acc,
    input  wire logic [WIDTH-1:0] i_operand,
    input  wire logic [3:0]       i_op,
    input  wire logic             i_cin,
    output logic      [WIDTH-1:0] o_result,
    output logic                  o_carry
);

    logic [WIDTH:0] w_wide;

    always_comb begin
        w_wide   = '0;
        o_result = i_acc;
        o_carry  = 1'b0;
        case (i_op)
            OP_LDA: o_result = i_operand;
            OP_ADD: begin
                w_wide   = {1'b0, i_acc} + {1'b0, i_operand} + {{WIDTH{1'b0}}, i_cin};
                o_result = w_wide[WIDTH-1:0];
                o_carry  = w_wide[WIDTH];
            end
            // Bit WIDTH of the extended difference is the borrow.
            OP_SUB: begin
                w_wide   = {1'b0, i_acc} - {1'b0, i_operand};
                o_result = w_wide[WIDTH-1:0];
                o_carry  = w_wide[WIDTH];
            end
            OP_AND: o_result = i_acc & i_operand;
            OP_OR:  o_result = i_acc | i_operand;
            OP_XOR: o_result = i_acc ^ i_operand;
            OP_NOT: o_result = ~i_acc;
            OP_SHL: begin
                o_result = {i_acc[WIDTH-2:0], 1'b0};
                o_carry  = i_acc[WIDTH-1];
            end
            OP_SHR: begin
                o_result = {1'b0, i_acc[WIDTH-1:1]};
                o_carry  = i_acc[0];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pmdatapath_seq.sv
`default_nettype none
// ============================================================================
// Module : pmdatapath_seq
// Brief  : Sequenced accumulator datapath with register file and ALU.
//          Define PM_MUL_EN to add the multi-cycle shift-add multiplier.
// Rev    : 1.0
// ============================================================================
module pmdatapath_seq
    import pm_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NREG  = 4,
    localparam int AW    = $clog2(NREG)
) (
    input  wire logic             clk,
    input  wire logic             clr,
    pmdatapath_seq_if.slave       cmd,
    input  wire logic [AW-1:0]    rd_sel,
    output logic      [WIDTH-1:0] rd_data,
    output logic      [WIDTH-1:0] acc,
    output logic                  carry,
    output logic                  zero,
    output logic                  done,
    output logic                  err
);

    state_t           r_state;
    logic [3:0]       r_op;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_data;
    logic             r_cin;
    logic [WIDTH-1:0] r_regs [NREG];
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_zero;
    logic             r_done;
    logic             r_err;

    logic [WIDTH-1:0] w_operand;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;
    logic             w_addr_ok;

    assign w_addr_ok = (int'(cmd.addr) < NREG);
    assign w_operand = r_regs[r_addr];
    assign rd_data   = (int'(rd_sel) < NREG) ? r_regs[rd_sel] : '0;
    assign cmd.ready = (r_state == ST_IDLE);
    assign acc       = r_acc;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign done      = r_done;
    assign err       = r_err;

    pmalu_gen #(.WIDTH(WIDTH)) u_alu (
        .i_acc     (r_acc),
        .i_operand (w_operand),
        .i_op      (r_op),
        .i_cin     (r_cin),
        .o_result  (w_alu_result),
        .o_carry   (w_alu_carry)
    );

`ifdef PM_MUL_EN
    localparam int                c_step_w    = $clog2(WIDTH + 1);
    localparam logic [c_step_w-1:0] c_last_step = c_step_w'(WIDTH - 1);

    logic [WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [WIDTH-1:0]    r_prod;
    logic [c_step_w-1:0] r_step;
    logic [WIDTH-1:0]    w_prod_next;

    // Only the low WIDTH bits of the product are kept, so bits shifted out of mcand are dropped.
    assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_addr  <= '0;
            r_data  <= '0;
            r_cin   <= 1'b0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
`ifdef PM_MUL_EN
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_step   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd.valid) begin
                        if (is_legal_op(cmd.op) && w_addr_ok) begin
                            r_op    <= cmd.op;
                            r_addr  <= cmd.addr;
                            r_data  <= cmd.data;
                            r_cin   <= cmd.cin;
                            r_state <= ST_EXEC;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
`ifdef PM_MUL_EN
                    if (r_op == OP_MUL) begin
                        r_mcand  <= r_acc;
                        r_mplier <= w_operand;
                        r_prod   <= '0;
                        r_step   <= '0;
                        r_state  <= ST_MUL;
                    end else
`endif
                    begin
                        case (r_op)
                            OP_LDR:  r_regs[r_addr] <= r_data;
                            OP_STA:  r_regs[r_addr] <= r_acc;
                            default: ;
                        endcase
                        if (writes_acc(r_op)) begin
                            r_acc   <= w_alu_result;
                            r_carry <= w_alu_carry;
                            r_zero  <= (w_alu_result == '0);
                        end
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
`ifdef PM_MUL_EN
                ST_MUL: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_step   <= r_step + 1'b1;
                    if (r_step == c_last_step) begin
                        r_acc   <= w_prod_next;
                        r_carry <= 1'b0;
                        r_zero  <= (w_prod_next == '0);
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmdatapath_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_pmdatapath_seq
// Brief  : Self-checking bench for pmdatapath_seq against an arithmetic model.
// Rev    : 1.0
// ============================================================================
module tb_pmdatapath_seq;

    localparam int W = 4;
    localparam int N = 4;
    localparam int M = 1 << W;
`ifdef PM_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   rd_sel;
    logic [W-1:0] rd_data, acc;
    logic         carry, zero, done, err;

    pmdatapath_seq_if #(.WIDTH(W), .NREG(N)) bus ();
    pmdatapath_seq #(.WIDTH(W), .NREG(N)) u_dut (
        .clk(clk), .clr(clr), .cmd(bus), .rd_sel(rd_sel), .rd_data(rd_data),
        .acc(acc), .carry(carry), .zero(zero), .done(done), .err(err)
    );

    // Second instance with a non-power-of-two register file for range errors.
    logic [1:0]   rd_sel3;
    logic [W-1:0] rd_data3, acc3;
    logic         carry3, zero3, done3, err3;

    pmdatapath_seq_if #(.WIDTH(W), .NREG(3)) bus3 ();
    pmdatapath_seq #(.WIDTH(W), .NREG(3)) u_dut3 (
        .clk(clk), .clr(clr), .cmd(bus3), .rd_sel(rd_sel3), .rd_data(rd_data3),
        .acc(acc3), .carry(carry3), .zero(zero3), .done(done3), .err(err3)
    );

    int errors = 0;
    int checks = 0;

    int m_acc, m_carry, m_zero;
    int m_regs [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_acc = 0; m_carry = 0; m_zero = 1;
        for (int i = 0; i < N; i++) m_regs[i] = 0;
    endfunction

    function automatic void set_acc(input int v, input int cy);
        m_acc = v; m_carry = cy; m_zero = (v == 0) ? 1 : 0;
    endfunction

    // Returns 1 when the command must be rejected with err.
    function automatic bit model_cmd(input int op, input int a, input int d, input int c);
        int r, s;
        if (!((op <= 11) || (MUL_EN && op == 12)) || a >= N) return 1'b1;
        r = m_regs[a];
        case (op)
            1:  m_regs[a] = d;
            2:  set_acc(r, 0);
            3:  m_regs[a] = m_acc;
            4:  begin s = m_acc + r + c; set_acc(s % M, (s >= M) ? 1 : 0); end
            5:  set_acc((m_acc - r + M) % M, (m_acc < r) ? 1 : 0);
            6:  set_acc(m_acc & r, 0);
            7:  set_acc(m_acc | r, 0);
            8:  set_acc(m_acc ^ r, 0);
            9:  set_acc((M - 1) - m_acc, 0);
            10: set_acc((m_acc * 2) % M, (m_acc >= M / 2) ? 1 : 0);
            11: set_acc(m_acc / 2, m_acc % 2);
            12: set_acc((m_acc * r) % M, 0);
            default: ;
        endcase
        return 1'b0;
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_acc"}, acc, m_acc);
        check({tag, "_carry"}, carry, m_carry);
        check({tag, "_zero"}, zero, m_zero);
        for (int i = 0; i < N; i++) begin
            rd_sel = 2'(i);
            #1;
            check({tag, "_rd"}, rd_data, m_regs[i]);
        end
    endtask

    // Issue one command, watch done/err timing, then compare with the model.
    task automatic run_cmd(input int op, input int a, input int d, input int c, input bit hold);
        bit exp_err;
        int lat, ndone, nerr, tdone, terr;
        logic rdy0;
        @(negedge clk);
        bus.valid = 1'b1; bus.op = 4'(op); bus.addr = 2'(a); bus.data = 4'(d); bus.cin = 1'(c);
        @(posedge clk); #1;
        if (!hold) bus.valid = 1'b0;
        exp_err = model_cmd(op, a, d, c);
        lat = (op == 12) ? W + 1 : 1;
        ndone = 0; nerr = 0; tdone = -1; terr = -1; rdy0 = 1'b0;
        for (int i = 0; i <= W + 2; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (i == 0) rdy0 = bus.ready;
            if (i == 1) bus.valid = 1'b0;
            if (done) begin ndone++; if (tdone < 0) tdone = i; end
            if (err)  begin nerr++;  if (terr < 0)  terr = i;  end
        end
        if (exp_err) begin
            check("err_count", nerr, 1);
            check("err_cycle", terr, 0);
            check("err_no_done", ndone, 0);
            check("err_ready", rdy0, 1);
        end else begin
            check("done_count", ndone, 1);
            check("done_cycle", tdone, lat);
            check("no_err", nerr, 0);
            check("busy_ready", rdy0, 0);
        end
        check("idle_ready", bus.ready, 1);
        check_model("cmd");
    endtask

    initial begin
        int ops [8], adr [8], dat [8], cis [8];
        int idx, nd, stop_cyc;

        bus.valid = 1'b0; bus.op = '0; bus.addr = '0; bus.data = '0; bus.cin = 1'b0;
        bus3.valid = 1'b0; bus3.op = '0; bus3.addr = '0; bus3.data = '0; bus3.cin = 1'b0;
        rd_sel = '0; rd_sel3 = '0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk) clr = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", bus.ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check_model("rst");

        // Directed arithmetic sequence
        run_cmd(1, 1, 9, 0, 1'b0);
        run_cmd(2, 1, 0, 0, 1'b0);
        run_cmd(4, 1, 0, 1, 1'b0);
        check("add_acc", acc, 4'h3);
        check("add_carry", carry, 1);
        check("add_zero", zero, 0);
        run_cmd(5, 1, 0, 0, 1'b0);
        check("sub_acc", acc, 4'hA);
        check("sub_borrow", carry, 1);

        // Zero path; valid held through EXEC must not start a second command
        run_cmd(1, 2, 0, 0, 1'b1);
        run_cmd(2, 2, 0, 0, 1'b1);
        run_cmd(11, 0, 0, 0, 1'b0);
        check("shr_acc", acc, 0);
        check("shr_zero", zero, 1);
        run_cmd(3, 3, 0, 0, 1'b0);
        rd_sel = 2'd3; #1;
        check("sta_r3", rd_data, 0);

        // Illegal opcodes
        run_cmd(1, 1, 4'h6, 0, 1'b0);
        run_cmd(13, 1, 4'hF, 0, 1'b0);
        run_cmd(12, 1, 0, 0, 1'b0);

`ifdef PM_MUL_EN
        run_cmd(1, 0, 3, 0, 1'b0);
        run_cmd(1, 1, 5, 0, 1'b0);
        run_cmd(2, 1, 0, 0, 1'b0);
        run_cmd(12, 0, 0, 0, 1'b0);
        check("mul_acc", acc, 4'hF);
        check("mul_carry", carry, 0);

        // Abort a multiply with clr partway through
        run_cmd(2, 1, 0, 0, 1'b0);
        @(negedge clk);
        bus.valid = 1'b1; bus.op = 4'd12; bus.addr = 2'd0;
        @(posedge clk); #1 bus.valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) clr = 1'b0;
        #1;
        model_reset();
        check("abort_ready", bus.ready, 1);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check_model("abort");
        @(negedge clk) clr = 1'b1;
        nd = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);
        check_model("abort_after");
`endif

        // Random commands
        for (int k = 0; k < 30; k++) begin
            run_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 1'b0);
        end

        // Back-to-back with valid held high
        for (int k = 0; k < 8; k++) begin
            ops[k] = int'($urandom_range(1, 11));
            adr[k] = int'($urandom_range(0, 3));
            dat[k] = int'($urandom_range(0, 15));
            cis[k] = int'($urandom_range(0, 1));
        end
        idx = 0; nd = 0; stop_cyc = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (done) nd++;
            if (bus.ready) begin
                if (idx < 8) begin
                    bus.valid = 1'b1;
                    bus.op = 4'(ops[idx]); bus.addr = 2'(adr[idx]);
                    bus.data = 4'(dat[idx]); bus.cin = 1'(cis[idx]);
                    void'(model_cmd(ops[idx], adr[idx], dat[idx], cis[idx]));
                    idx++;
                end else begin
                    bus.valid = 1'b0;
                    stop_cyc = cyc;
                    break;
                end
            end
        end
        bus.valid = 1'b0;
        check("b2b_cycles", stop_cyc, 16);
        check("b2b_dones", nd, 8);
        @(posedge clk); #1;
        check_model("b2b");

        // Address out of range on the three-entry instance
        @(negedge clk);
        bus3.valid = 1'b1; bus3.op = 4'd1; bus3.addr = 2'd3; bus3.data = 4'h5;
        @(posedge clk); #1;
        bus3.valid = 1'b0;
        check("range_err", err3, 1);
        check("range_ready", bus3.ready, 1);
        @(posedge clk); #1;
        check("range_err_pulse", err3, 0);
        check("range_acc", acc3, 0);
        @(negedge clk);
        bus3.valid = 1'b1; bus3.op = 4'd1; bus3.addr = 2'd2; bus3.data = 4'h5;
        @(posedge clk); #1;
        bus3.valid = 1'b0;
        check("inrange_no_err", err3, 0);
        @(posedge clk); #1;
        check("inrange_done", done3, 1);
        rd_sel3 = 2'd2; #1;
        check("inrange_rd", rd_data3, 4'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
